// File: rtl/rs_add_unit.sv
// ADD/SUB reservation stations with a single-issue adder and CDB result port.
// Entries snoop the CDB for pending operands; one operation is in flight at a time.
module rs_add_unit #(
    parameter int DATA_W  = 16,
    parameter int N_RS    = 2,
    parameter int ADD_LAT = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              issueValid,
    output logic              issueReady,
    output logic [1:0]        issueLabel,
    input  logic              issueOp,
    input  logic [2:0]        issueDest,
    input  logic [DATA_W-1:0] issueVj,
    input  logic [DATA_W-1:0] issueVk,
    input  logic              issueQjBusy,
    input  logic              issueQkBusy,
    input  logic [2:0]        issueQj,
    input  logic [2:0]        issueQk,
    input  logic [DATA_W+6:0] cdb,
    output logic              resReq,
    output logic [DATA_W+6:0] resData,
    input  logic              resGrant,
    output logic [N_RS-1:0]   busyVec
);

    localparam logic [2:0] ST_FREE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] U_IDLE = 2'd0;
    localparam logic [1:0] U_EXEC = 2'd1;
    localparam logic [1:0] U_WB   = 2'd2;

    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    logic [2:0]        st_q   [N_RS];
    logic [2:0]        st_d   [N_RS];
    logic              op_q   [N_RS];
    logic              op_d   [N_RS];
    logic [2:0]        dest_q [N_RS];
    logic [2:0]        dest_d [N_RS];
    logic [DATA_W-1:0] vj_q   [N_RS];
    logic [DATA_W-1:0] vj_d   [N_RS];
    logic [DATA_W-1:0] vk_q   [N_RS];
    logic [DATA_W-1:0] vk_d   [N_RS];
    logic [2:0]        qj_q   [N_RS];
    logic [2:0]        qj_d   [N_RS];
    logic [2:0]        qk_q   [N_RS];
    logic [2:0]        qk_d   [N_RS];
    logic              qjb_q  [N_RS];
    logic              qjb_d  [N_RS];
    logic              qkb_q  [N_RS];
    logic              qkb_d  [N_RS];

    logic [1:0]        unit_q, unit_d;
    logic [1:0]        exec_idx_q, exec_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W+6:0] res_q, res_d;

    logic              cdb_valid;
    logic [2:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              unused_cdb_dest;
    logic              bypass_j, bypass_k;

    logic              any_ready;
    logic [1:0]        rdy_idx;
    logic              sel_op;
    logic [2:0]        sel_dest;
    logic [DATA_W-1:0] sel_vj, sel_vk, result;

    assign cdb_valid       = cdb[DATA_W+6];
    assign cdb_tag         = cdb[DATA_W+5:DATA_W+3];
    assign cdb_data        = cdb[DATA_W-1:0];
    assign unused_cdb_dest = ^cdb[DATA_W+2:DATA_W];

    // An operand pending on the tag being broadcast right now is taken straight off the CDB.
    assign bypass_j = issueQjBusy && cdb_valid && (issueQj == cdb_tag);
    assign bypass_k = issueQkBusy && cdb_valid && (issueQk == cdb_tag);

    assign resReq  = (unit_q == U_WB);
    assign resData = res_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        issueReady = 1'b0;
        issueLabel = 2'd0;
        any_ready  = 1'b0;
        rdy_idx    = 2'd0;
        for (int i = N_RS - 1; i >= 0; i--) begin
            busyVec[i] = (st_q[i] != ST_FREE);
            if (st_q[i] == ST_FREE) begin
                issueReady = 1'b1;
                issueLabel = 2'(i);
            end
            if (st_q[i] == ST_READY) begin
                any_ready = 1'b1;
                rdy_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        sel_op   = 1'b0;
        sel_dest = 3'd0;
        sel_vj   = '0;
        sel_vk   = '0;
        for (int i = 0; i < N_RS; i++) begin
            if (exec_idx_q == 2'(i)) begin
                sel_op   = op_q[i];
                sel_dest = dest_q[i];
                sel_vj   = vj_q[i];
                sel_vk   = vk_q[i];
            end
        end
        result = sel_op ? (sel_vj - sel_vk) : (sel_vj + sel_vk);
    end

    always_comb begin
        st_d       = st_q;
        op_d       = op_q;
        dest_d     = dest_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        qjb_d      = qjb_q;
        qkb_d      = qkb_q;
        unit_d     = unit_q;
        exec_idx_d = exec_idx_q;
        cnt_d      = cnt_q;
        res_d      = res_q;

        case (unit_q)
            U_IDLE: begin
                if (any_ready) begin
                    unit_d     = U_EXEC;
                    exec_idx_d = rdy_idx;
                    cnt_d      = CNT_W'(ADD_LAT - 1);
                    for (int i = 0; i < N_RS; i++)
                        if (rdy_idx == 2'(i)) st_d[i] = ST_EXEC;
                end
            end
            U_EXEC: begin
                if (cnt_q == '0) begin
                    unit_d = U_WB;
                    res_d  = {1'b1, 1'b0, exec_idx_q, sel_dest, result};
                    for (int i = 0; i < N_RS; i++)
                        if (exec_idx_q == 2'(i)) st_d[i] = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            U_WB: begin
                if (resGrant) begin
                    unit_d = U_IDLE;
                    res_d  = '0;
                    for (int i = 0; i < N_RS; i++)
                        if (exec_idx_q == 2'(i)) st_d[i] = ST_FREE;
                end
            end
            default: unit_d = U_IDLE;
        endcase

        for (int i = 0; i < N_RS; i++) begin
            if (st_q[i] == ST_WAIT) begin
                if (qjb_q[i] && cdb_valid && (qj_q[i] == cdb_tag)) begin
                    vj_d[i]  = cdb_data;
                    qjb_d[i] = 1'b0;
                end
                if (qkb_q[i] && cdb_valid && (qk_q[i] == cdb_tag)) begin
                    vk_d[i]  = cdb_data;
                    qkb_d[i] = 1'b0;
                end
                if (!qjb_d[i] && !qkb_d[i]) st_d[i] = ST_READY;
            end
        end

        // The issue target is always FREE, so it never collides with snoop, dispatch or release.
        if (issueValid && issueReady) begin
            for (int i = 0; i < N_RS; i++) begin
                if (issueLabel == 2'(i)) begin
                    op_d[i]   = issueOp;
                    dest_d[i] = issueDest;
                    qj_d[i]   = issueQj;
                    qk_d[i]   = issueQk;
                    vj_d[i]   = bypass_j ? cdb_data : issueVj;
                    vk_d[i]   = bypass_k ? cdb_data : issueVk;
                    qjb_d[i]  = issueQjBusy && !bypass_j;
                    qkb_d[i]  = issueQkBusy && !bypass_k;
                    st_d[i]   = ((issueQjBusy && !bypass_j) || (issueQkBusy && !bypass_k))
                                ? ST_WAIT : ST_READY;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: the entry array is a handful of flops, so every field is reset to keep outputs X-free.
            for (int i = 0; i < N_RS; i++) begin
                st_q[i]   <= ST_FREE;
                op_q[i]   <= 1'b0;
                dest_q[i] <= 3'd0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= 3'd0;
                qk_q[i]   <= 3'd0;
                qjb_q[i]  <= 1'b0;
                qkb_q[i]  <= 1'b0;
            end
            unit_q     <= U_IDLE;
            exec_idx_q <= 2'd0;
            cnt_q      <= '0;
            res_q      <= '0;
        end else begin
            st_q       <= st_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            qjb_q      <= qjb_d;
            qkb_q      <= qkb_d;
            unit_q     <= unit_d;
            exec_idx_q <= exec_idx_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_rs_add_unit.sv
// Directed bench for rs_add_unit: an entry-level behavioural model is compared every cycle,
// and literal expectations pin the key scenarios.
module tb_rs_add_unit;

    localparam int DATA_W  = 16;
    localparam int N_RS    = 2;
    localparam int ADD_LAT = 2;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic              issueValid, issueReady, issueOp, issueQjBusy, issueQkBusy;
    logic [1:0]        issueLabel;
    logic [2:0]        issueDest, issueQj, issueQk;
    logic [DATA_W-1:0] issueVj, issueVk;
    logic [DATA_W+6:0] cdb, resData;
    logic              resReq, resGrant;
    logic [N_RS-1:0]   busyVec;

    int total = 0;
    int bad   = 0;

    rs_add_unit #(.DATA_W(DATA_W), .N_RS(N_RS), .ADD_LAT(ADD_LAT)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .issueValid(issueValid), .issueReady(issueReady), .issueLabel(issueLabel),
        .issueOp(issueOp), .issueDest(issueDest), .issueVj(issueVj), .issueVk(issueVk),
        .issueQjBusy(issueQjBusy), .issueQkBusy(issueQkBusy),
        .issueQj(issueQj), .issueQk(issueQk), .cdb(cdb),
        .resReq(resReq), .resData(resData), .resGrant(resGrant), .busyVec(busyVec)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: which entries hold an instruction, their operands/pending tags,
    // and the one operation in flight with its remaining latency.
    bit          m_used [N_RS];
    bit          m_pj   [N_RS];
    bit          m_pk   [N_RS];
    logic [2:0]  m_tj   [N_RS];
    logic [2:0]  m_tk   [N_RS];
    logic [15:0] m_vj   [N_RS];
    logic [15:0] m_vk   [N_RS];
    bit          m_op   [N_RS];
    logic [2:0]  m_dest [N_RS];
    int          m_act;
    int          m_rem;
    bit          m_wb;
    logic [22:0] m_res;

    always @(posedge Clock or negedge Resetn) begin : model
        int          fl;
        int          pick;
        logic [15:0] sum;
        if (!Resetn) begin
            for (int i = 0; i < N_RS; i++) begin
                m_used[i] = 0; m_pj[i] = 0; m_pk[i] = 0;
            end
            m_act = -1; m_rem = 0; m_wb = 0; m_res = '0;
        end else begin
            fl = -1;
            for (int i = N_RS - 1; i >= 0; i--) if (!m_used[i]) fl = i;
            if (m_act < 0) begin
                pick = -1;
                for (int i = N_RS - 1; i >= 0; i--)
                    if (m_used[i] && !m_pj[i] && !m_pk[i]) pick = i;
                if (pick >= 0) begin
                    m_act = pick;
                    m_rem = ADD_LAT;
                end
            end else if (!m_wb) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    sum   = m_op[m_act] ? (m_vj[m_act] - m_vk[m_act]) : (m_vj[m_act] + m_vk[m_act]);
                    m_wb  = 1;
                    m_res = {1'b1, 1'b0, 2'(m_act), m_dest[m_act], sum};
                end
            end else if (resGrant) begin
                m_used[m_act] = 0;
                m_wb  = 0;
                m_act = -1;
            end
            for (int i = 0; i < N_RS; i++) begin
                if (m_used[i] && cdb[22]) begin
                    if (m_pj[i] && m_tj[i] == cdb[21:19]) begin m_vj[i] = cdb[15:0]; m_pj[i] = 0; end
                    if (m_pk[i] && m_tk[i] == cdb[21:19]) begin m_vk[i] = cdb[15:0]; m_pk[i] = 0; end
                end
            end
            if (issueValid && fl >= 0) begin
                m_used[fl] = 1;
                m_op[fl]   = issueOp;
                m_dest[fl] = issueDest;
                m_tj[fl]   = issueQj;
                m_tk[fl]   = issueQk;
                m_pj[fl]   = issueQjBusy && !(cdb[22] && issueQj == cdb[21:19]);
                m_pk[fl]   = issueQkBusy && !(cdb[22] && issueQk == cdb[21:19]);
                m_vj[fl]   = (issueQjBusy && !m_pj[fl]) ? cdb[15:0] : issueVj;
                m_vk[fl]   = (issueQkBusy && !m_pk[fl]) ? cdb[15:0] : issueVk;
            end
        end
    end

    always @(negedge Clock) begin : compare
        logic [N_RS-1:0] eb;
        int              ef;
        if (Resetn) begin
            ef = -1;
            for (int i = N_RS - 1; i >= 0; i--) begin
                eb[i] = m_used[i];
                if (!m_used[i]) ef = i;
            end
            check("model_resReq", 32'(resReq), 32'(m_wb));
            check("model_resData", 32'(resData), m_wb ? 32'(m_res) : 32'd0);
            check("model_busyVec", 32'(busyVec), 32'(eb));
            check("model_issueReady", 32'(issueReady), 32'(ef >= 0));
            if (ef >= 0) check("model_issueLabel", 32'(issueLabel), 32'(ef));
        end
    end

    function automatic logic [22:0] mk_cdb(input logic [2:0] tag, input logic [15:0] d);
        return {1'b1, tag, 3'b000, d};
    endfunction

    // Called just after a falling edge; returns on the falling edge after the issue edge.
    task automatic issue(input logic op, input logic [2:0] dest, input logic [15:0] vj,
                         input logic [15:0] vk, input logic qjb, input logic [2:0] qj,
                         input logic qkb, input logic [2:0] qk);
        issueValid = 1; issueOp = op; issueDest = dest; issueVj = vj; issueVk = vk;
        issueQjBusy = qjb; issueQj = qj; issueQkBusy = qkb; issueQk = qk;
        @(negedge Clock);
        issueValid = 0; issueQjBusy = 0; issueQkBusy = 0;
    endtask

    task automatic wait_req();
        for (int n = 0; n < 20 && !resReq; n++) @(negedge Clock);
        check("req_timeout", 32'(resReq), 32'd1);
    endtask

    task automatic grant();
        resGrant = 1;
        @(negedge Clock);
        resGrant = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Resetn = 0; issueValid = 0; issueOp = 0; issueDest = 0; issueVj = 0; issueVk = 0;
        issueQjBusy = 0; issueQkBusy = 0; issueQj = 0; issueQk = 0; cdb = '0; resGrant = 0;
        repeat (2) @(negedge Clock);
        check("rst_issueReady", 32'(issueReady), 32'd1);
        check("rst_issueLabel", 32'(issueLabel), 32'd0);
        check("rst_busyVec", 32'(busyVec), 32'd0);
        check("rst_resReq", 32'(resReq), 32'd0);
        check("rst_resData", 32'(resData), 32'd0);
        #2 Resetn = 1;

        // ADD R2 = 5 + 7, accepted on the first edge after reset release
        issue(0, 3'd2, 16'd5, 16'd7, 0, 3'd0, 0, 3'd0);
        check("add_busy", 32'(busyVec), 32'h1);
        repeat (2) @(negedge Clock);
        check("add_req_early", 32'(resReq), 32'd0);
        @(negedge Clock);
        check("add_req_lat", 32'(resReq), 32'd1);
        check("add_data", 32'(resData), 32'h42000C);
        grant();
        check("add_freed", 32'(busyVec), 32'h0);

        // wrap-around in both directions
        issue(1, 3'd1, 16'd0, 16'd1, 0, 3'd0, 0, 3'd0);
        wait_req();
        check("sub_wrap", 32'(resData), 32'h41FFFF);
        grant();
        issue(0, 3'd3, 16'hFFFF, 16'd2, 0, 3'd0, 0, 3'd0);
        wait_req();
        check("add_wrap", 32'(resData), 32'h430001);
        grant();

        // Qj pending on MUL label 1: wrong unit bit must not wake it
        issue(0, 3'd3, 16'hDEAD, 16'd3, 1, 3'b101, 0, 3'd0);
        cdb = mk_cdb(3'b001, 16'd99);
        @(negedge Clock);
        cdb = '0;
        repeat (3) @(negedge Clock);
        check("wrong_tag_req", 32'(resReq), 32'd0);
        check("wrong_tag_busy", 32'(busyVec), 32'h1);
        cdb = mk_cdb(3'b101, 16'd9);
        @(negedge Clock);
        cdb = '0;
        repeat (2) @(negedge Clock);
        check("wake_req_early", 32'(resReq), 32'd0);
        @(negedge Clock);
        check("wake_req", 32'(resReq), 32'd1);
        check("wake_data", 32'(resData), 32'h43000C);
        grant();

        // both entries full; result held until granted; issue attempts ignored
        issue(0, 3'd4, 16'd10, 16'd20, 0, 3'd0, 0, 3'd0);
        issue(1, 3'd5, 16'd50, 16'd8, 0, 3'd0, 0, 3'd0);
        check("full_ready", 32'(issueReady), 32'd0);
        check("full_busy", 32'(busyVec), 32'h3);
        wait_req();
        issueValid = 1; issueOp = 0; issueDest = 3'd7; issueVj = 16'd1; issueVk = 16'd1;
        for (int n = 0; n < 5; n++) begin
            check("hold_data", 32'(resData), 32'h44001E);
            @(negedge Clock);
        end
        check("hold_busy", 32'(busyVec), 32'h3);
        grant();
        issueValid = 0;
        check("freed_ready", 32'(issueReady), 32'd1);
        check("freed_label", 32'(issueLabel), 32'd0);
        check("freed_busy", 32'(busyVec), 32'h2);
        wait_req();
        check("second_data", 32'(resData), 32'h4D002A);
        grant();

        // own broadcast looped back on the CDB wakes a dependent entry
        issue(0, 3'd1, 16'd1, 16'd2, 0, 3'd0, 0, 3'd0);
        issue(0, 3'd2, 16'd0, 16'd5, 1, 3'b000, 0, 3'd0);
        wait_req();
        check("loop_first", 32'(resData), 32'h410003);
        cdb = resData;
        grant();
        cdb = '0;
        wait_req();
        check("loop_second", 32'(resData), 32'h4A0008);
        grant();

        // issue bypass: Qk tag broadcast in the issue cycle
        cdb = mk_cdb(3'b100, 16'd6);
        issue(0, 3'd6, 16'd4, 16'd0, 0, 3'd0, 1, 3'b100);
        cdb = '0;
        repeat (2) @(negedge Clock);
        check("bypass_req_early", 32'(resReq), 32'd0);
        @(negedge Clock);
        check("bypass_req", 32'(resReq), 32'd1);
        check("bypass_data", 32'(resData), 32'h46000A);
        grant();

        // asynchronous reset mid-EXEC, then a clean operation
        issue(0, 3'd7, 16'd1, 16'd1, 0, 3'd0, 0, 3'd0);
        @(negedge Clock);
        #2 Resetn = 0;
        #1;
        check("arst_busy", 32'(busyVec), 32'h0);
        check("arst_req", 32'(resReq), 32'd0);
        check("arst_ready", 32'(issueReady), 32'd1);
        @(negedge Clock);
        #2 Resetn = 1;
        issue(0, 3'd5, 16'd100, 16'd23, 0, 3'd0, 0, 3'd0);
        repeat (2) @(negedge Clock);
        @(negedge Clock);
        check("post_rst_req", 32'(resReq), 32'd1);
        check("post_rst_data", 32'(resData), 32'h45007B);

        // reset while a result is waiting for the arbiter
        #2 Resetn = 0;
        #1;
        check("arst_wb_req", 32'(resReq), 32'd0);
        check("arst_wb_data", 32'(resData), 32'd0);
        @(negedge Clock);
        #2 Resetn = 1;
        repeat (2) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
